// File: rtl/alu_seq_pkg.sv
// Shared constants, state encoding and field layout for the ALU execution stage.
// The add result helper keeps the carry in bit 12 and zero-extends the rest.
package alu_seq_pkg;

   localparam int OPERAND_W  = 12;
   localparam int OP_W       = 2;
   localparam int FIFO_IN_W  = 26;
   localparam int FIFO_OUT_W = 25;

   // fifo_in_data layout: {op, data1, data0}
   localparam int DATA0_LSB = 0;
   localparam int DATA1_LSB = 12;
   localparam int OP_LSB    = 24;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FETCH = 2'd1,
      ST_EXEC  = 2'd2,
      ST_PUSH  = 2'd3
   } state_t;

   localparam logic [1:0]  OP_ADD     = 2'b01;
   localparam logic [1:0]  OP_MUL     = 2'b10;
   localparam logic [24:0] ERR_RESULT = 25'h1FF_FFFF;

   function automatic logic [FIFO_OUT_W-1:0] add_result(input logic [OPERAND_W-1:0] a,
                                                        input logic [OPERAND_W-1:0] b);
      logic [OPERAND_W:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return {{(FIFO_OUT_W-OPERAND_W-1){1'b0}}, sum};
   endfunction

endpackage

// File: rtl/alu_sequencer_shift_add_multiplier.sv
// Unsigned 12x12 shift-add multiplier: one multiplier bit per cycle, LSB first.
// done is high in the final step; product then already includes that step.
module shift_add_multiplier
   import alu_seq_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start,
   input  logic [OPERAND_W-1:0]   multiplicand,
   input  logic [OPERAND_W-1:0]   multiplier,
   output logic                   done,
   output logic [2*OPERAND_W-1:0] product
);

   logic                   rst;
   logic [2*OPERAND_W-1:0] acc_reg, acc_next;
   logic [3:0]             cnt_reg, cnt_next;
   logic                   run_reg, run_next;
   logic                   last_step;

   assign rst       = !rst_n;
   assign last_step = run_reg && (cnt_reg == 4'(OPERAND_W - 1));

   always_comb begin
      acc_next = acc_reg;
      cnt_next = cnt_reg;
      run_next = run_reg;
      if (start) begin
         acc_next = '0;
         cnt_next = '0;
         run_next = 1'b1;
      end else if (run_reg) begin
         if (multiplier[cnt_reg])
            acc_next = acc_reg + ({{OPERAND_W{1'b0}}, multiplicand} << cnt_reg);
         cnt_next = cnt_reg + 4'd1;
         if (last_step)
            run_next = 1'b0;
      end
   end

   d_ff_async_en #(.WIDTH(2*OPERAND_W)) u_acc (
      .clk(clk), .rst(rst), .en(1'b1), .d(acc_next), .q(acc_reg)
   );
   d_ff_async_en #(.WIDTH(4)) u_cnt (
      .clk(clk), .rst(rst), .en(1'b1), .d(cnt_next), .q(cnt_reg)
   );
   d_ff_async_en #(.WIDTH(1)) u_run (
      .clk(clk), .rst(rst), .en(1'b1), .d(run_next), .q(run_reg)
   );

   assign done    = last_step;
   assign product = acc_next;

endmodule

// File: rtl/d_ff_async_en.sv
// Generic enabled register with asynchronous active-high clear.
module d_ff_async_en #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         q <= '0;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/alu_sequencer.sv
// Execution stage: pops one {op, data1, data0} command, computes add or
// multiply, and pushes the tagged 25-bit result. Commands never overlap.
module alu_sequencer
   import alu_seq_pkg::*;
#(
   parameter int OPERAND_SIZE   = OPERAND_W,
   parameter int OPERATION_SIZE = OP_W,
   parameter int FIFO_IN_WIDTH  = FIFO_IN_W,
   parameter int FIFO_OUT_WIDTH = FIFO_OUT_W
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      empty_in,
   input  logic [FIFO_IN_WIDTH-1:0]  fifo_in_data,
   output logic                      r_en_in,
   input  logic                      full_out,
   output logic                      w_en_out,
   output logic [FIFO_OUT_WIDTH-1:0] fifo_out_data,
   output logic                      busy
);

   logic                        rst;
   state_t                      state_reg, state_next;
   logic [OPERATION_SIZE-1:0]   op_in, op_reg;
   logic [OPERAND_SIZE-1:0]     data0_in, data1_in, data0_reg, data1_reg;
   logic [FIFO_OUT_WIDTH-1:0]   result_reg, result_next;
   logic                        capture, result_en;
   logic                        mul_start, mul_done;
   logic [2*OPERAND_SIZE-1:0]   mul_product;

   assign rst      = !rst_n;
   assign op_in    = fifo_in_data[OP_LSB    +: OPERATION_SIZE];
   assign data1_in = fifo_in_data[DATA1_LSB +: OPERAND_SIZE];
   assign data0_in = fifo_in_data[DATA0_LSB +: OPERAND_SIZE];

   // Read data arrives the cycle after the pop, i.e. while in FETCH.
   assign capture   = (state_reg == ST_FETCH);
   assign mul_start = capture && (op_in == OP_MUL);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next  = state_reg;
      r_en_in     = 1'b0;
      w_en_out    = 1'b0;
      result_en   = 1'b0;
      result_next = result_reg;
      case (state_reg)
         ST_IDLE: begin
            r_en_in = rst_n && !empty_in;
            if (!empty_in)
               state_next = ST_FETCH;
         end
         ST_FETCH: state_next = ST_EXEC;
         ST_EXEC: begin
            case (op_reg)
               OP_ADD: begin
                  result_next = add_result(data0_reg, data1_reg);
                  result_en   = 1'b1;
                  state_next  = ST_PUSH;
               end
               OP_MUL: begin
                  if (mul_done) begin
                     result_next = {1'b1, mul_product};
                     result_en   = 1'b1;
                     state_next  = ST_PUSH;
                  end
               end
               default: begin
                  result_next = ERR_RESULT;
                  result_en   = 1'b1;
                  state_next  = ST_PUSH;
               end
            endcase
         end
         ST_PUSH: begin
            w_en_out = !full_out;
            if (!full_out)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   d_ff_async_en #(.WIDTH(OPERATION_SIZE)) u_op_reg (
      .clk(clk), .rst(rst), .en(capture), .d(op_in), .q(op_reg)
   );
   d_ff_async_en #(.WIDTH(OPERAND_SIZE)) u_data0_reg (
      .clk(clk), .rst(rst), .en(capture), .d(data0_in), .q(data0_reg)
   );
   d_ff_async_en #(.WIDTH(OPERAND_SIZE)) u_data1_reg (
      .clk(clk), .rst(rst), .en(capture), .d(data1_in), .q(data1_reg)
   );
   d_ff_async_en #(.WIDTH(FIFO_OUT_WIDTH)) u_result_reg (
      .clk(clk), .rst(rst), .en(result_en), .d(result_next), .q(result_reg)
   );

   shift_add_multiplier u_mul (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (mul_start),
      .multiplicand (data0_reg),
      .multiplier   (data1_reg),
      .done         (mul_done),
      .product      (mul_product)
   );

   assign busy          = (state_reg != ST_IDLE);
   assign fifo_out_data = result_reg;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: FIFO_IN model, vector table, hand-written corner
// sequences and random commands checked against an arithmetic reference model.
module tb_alu_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        empty_in;
   logic [25:0] fifo_in_data = '0;
   logic        r_en_in;
   logic        full_out = 1'b0;
   logic        w_en_out;
   logic [24:0] fifo_out_data;
   logic        busy;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   logic [25:0] mem [0:255];
   int          wr_ptr = 0;
   int          rd_ptr = 0;

   assign empty_in = (rd_ptr == wr_ptr);

   always @(posedge clk) begin
      if (r_en_in) begin
         fifo_in_data <= mem[rd_ptr[7:0]];
         rd_ptr       <= rd_ptr + 1;
      end
   end

   alu_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .empty_in      (empty_in),
      .fifo_in_data  (fifo_in_data),
      .r_en_in       (r_en_in),
      .full_out      (full_out),
      .w_en_out      (w_en_out),
      .fifo_out_data (fifo_out_data),
      .busy          (busy)
   );

   typedef struct {
      logic [1:0]  op;
      logic [11:0] d1;
      logic [11:0] d0;
      logic [24:0] exp_res;
      int          lat;
      int          stall;
   } vec_t;

   vec_t vecs [7];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [24:0] model_result(input logic [1:0] op, input logic [11:0] d1,
                                                input logic [11:0] d0);
      int unsigned a, b;
      a = d0;
      b = d1;
      if (op == 2'b01) return 25'(a + b);
      if (op == 2'b10) return 25'(a * b) | 25'h100_0000;
      return 25'h1FF_FFFF;
   endfunction

   function automatic int model_latency(input logic [1:0] op);
      return (op == 2'b10) ? 14 : 3;
   endfunction

   task automatic push_cmd(input logic [1:0] op, input logic [11:0] d1, input logic [11:0] d0);
      mem[wr_ptr[7:0]] = {op, d1, d0};
      wr_ptr = wr_ptr + 1;
   endtask

   // Called at a sample point; waits for the pop, then follows the command to its push.
   task automatic run_one(input string tag, input logic [24:0] exp_res, input int exp_lat,
                          input int stall, output int waited);
      bit seen;
      waited = 0;
      while (!r_en_in && waited < 40) begin
         @(posedge clk); #1;
         @(negedge clk);
         waited++;
      end
      check($sformatf("%s r_en", tag), {31'd0, r_en_in}, 32'd1);
      if (!r_en_in) return;
      check($sformatf("%s busy0", tag), {31'd0, busy}, 32'd0);
      seen = 1'b0;
      for (int c = 1; c <= exp_lat + stall + 3 && !seen; c++) begin
         @(posedge clk); #1;
         full_out = (c >= exp_lat) && (c < exp_lat + stall);
         @(negedge clk);
         if (w_en_out) begin
            seen = 1'b1;
            check($sformatf("%s latency", tag), c, exp_lat + stall);
            check($sformatf("%s result", tag), {7'd0, fifo_out_data}, {7'd0, exp_res});
            check($sformatf("%s busy_push", tag), {31'd0, busy}, 32'd1);
         end else begin
            check($sformatf("%s busy/r_en c%0d", tag, c), {30'd0, busy, r_en_in}, 32'd2);
            if (c >= exp_lat)
               check($sformatf("%s hold c%0d", tag, c), {7'd0, fifo_out_data}, {7'd0, exp_res});
         end
      end
      full_out = 1'b0;
      if (!seen)
         check($sformatf("%s push timeout", tag), {31'd0, w_en_out}, 32'd1);
      $display("txn %s exp=%07h lat=%0d stall=%0d got=%07h", tag, exp_res, exp_lat, stall,
               fifo_out_data);
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, w2;
      logic [1:0]  op;
      logic [11:0] d1, d0;

      vecs[0] = '{2'b01, 12'hFFF, 12'hFFF, 25'h000_1FFE, 3, 0};
      vecs[1] = '{2'b10, 12'hFFF, 12'hFFF, 25'h1FF_E001, 14, 0};
      vecs[2] = '{2'b00, 12'h001, 12'h001, 25'h1FF_FFFF, 3, 0};
      vecs[3] = '{2'b11, 12'hABC, 12'h123, 25'h1FF_FFFF, 3, 0};
      vecs[4] = '{2'b10, 12'h000, 12'hABC, 25'h100_0000, 14, 0};
      vecs[5] = '{2'b10, 12'hFFF, 12'h001, 25'h100_0FFF, 14, 0};
      vecs[6] = '{2'b01, 12'h0FF, 12'h001, 25'h000_0100, 3, 10};

      // Command waiting in FIFO_IN while reset is held: no pop may happen.
      push_cmd(2'b01, 12'h0FF, 12'h001);
      @(negedge clk); #1;
      check("reset busy", {31'd0, busy}, 32'd0);
      check("reset r_en", {31'd0, r_en_in}, 32'd0);
      check("reset w_en", {31'd0, w_en_out}, 32'd0);
      check("reset data", {7'd0, fifo_out_data}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      run_one("add_0ff_001", 25'h000_0100, 3, 0, w);

      for (int i = 0; i < 7; i++) begin
         push_cmd(vecs[i].op, vecs[i].d1, vecs[i].d0);
         run_one($sformatf("vec%0d", i), vecs[i].exp_res, vecs[i].lat, vecs[i].stall, w);
      end

      // Back-to-back: second pop exactly one cycle after the first push.
      push_cmd(2'b01, 12'd4, 12'd3);
      push_cmd(2'b10, 12'd6, 12'd5);
      run_one("b2b_add", 25'h000_0007, 3, 0, w);
      run_one("b2b_mul", 25'h100_001E, 14, 0, w2);
      check("b2b gap", w2, 1);

      // Back-pressure on a multiply as well.
      push_cmd(2'b10, 12'h123, 12'h456);
      run_one("bp_mul", model_result(2'b10, 12'h123, 12'h456), 14, 10, w);

      for (int i = 0; i < 20; i++) begin
         op = 2'($urandom_range(0, 9) < 5 ? 1 : ($urandom_range(0, 9) < 8 ? 2 : $urandom_range(0, 3)));
         d1 = 12'($urandom);
         d0 = 12'($urandom);
         push_cmd(op, d1, d0);
         run_one($sformatf("rnd%0d op%0d %03h*%03h", i, op, d1, d0), model_result(op, d1, d0),
                 model_latency(op), int'($urandom_range(0, 3)), w);
      end

      // Reset in the middle of a multiply: outputs drop at once, nothing is pushed.
      push_cmd(2'b10, 12'hFFF, 12'hFFF);
      w = 0;
      while (!r_en_in && w < 5) begin
         @(negedge clk);
         w++;
      end
      check("rst_mul r_en", {31'd0, r_en_in}, 32'd1);
      repeat (9) begin
         @(posedge clk); #1;
      end
      check("rst_mul busy_before", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("rst_mul busy", {31'd0, busy}, 32'd0);
      check("rst_mul r_en0", {31'd0, r_en_in}, 32'd0);
      check("rst_mul w_en", {31'd0, w_en_out}, 32'd0);
      check("rst_mul data", {7'd0, fifo_out_data}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check($sformatf("post_rst c%0d", c), {30'd0, w_en_out, busy}, 32'd0);
      end
      $display("txn rst_mid_mul discarded");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
